// File: rtl/ws2812_tx.sv
// WS2812 serial line driver: shifts 24-bit GRB pixels MSB-first onto an NRZ
// data line at WS2812 bit timing and closes each frame with a low latch period.
module ws2812_tx #(
    parameter int NUM_LEDS = 256,
    parameter int T0H      = 20,
    parameter int T1H      = 40,
    parameter int T_BIT    = 63,
    parameter int T_RESET  = 15000
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        start,
    input  logic        valid,
    input  logic [23:0] led_data,
    output logic        done_bit,
    output logic        done_dz,
    output logic        busy,
    output logic        dout
);

    localparam int CNT_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int PIX_W   = $clog2(NUM_LEDS + 1);

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(T_BIT - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(T_RESET - 1);
    localparam logic [CNT_W-1:0] HIGH_0     = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] HIGH_1     = CNT_W'(T1H);
    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PIX,
        SEND,
        LATCH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         bit_idx_q, bit_idx_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [23:0]        shreg_q, shreg_d;
    logic               dout_d, done_bit_d, done_dz_d, busy_d;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            pix_cnt_q <= '0;
            shreg_q   <= '0;
            dout      <= 1'b0;
            done_bit  <= 1'b0;
            done_dz   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            pix_cnt_q <= pix_cnt_d;
            shreg_q   <= shreg_d;
            dout      <= dout_d;
            done_bit  <= done_bit_d;
            done_dz   <= done_dz_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        pix_cnt_d  = pix_cnt_q;
        shreg_d    = shreg_q;
        done_bit_d = 1'b0;
        done_dz_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pix_cnt_d = '0;
                    state_d   = WAIT_PIX;
                    if (valid) begin
                        shreg_d   = led_data;
                        bit_idx_d = 5'd23;
                        cnt_d     = '0;
                        state_d   = SEND;
                    end
                end
            end
            WAIT_PIX: begin
                if (valid) begin
                    shreg_d   = led_data;
                    bit_idx_d = 5'd23;
                    cnt_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q != 5'd0) begin
                        shreg_d   = {shreg_q[22:0], 1'b0};
                        bit_idx_d = bit_idx_q - 5'd1;
                    end else begin
                        pix_cnt_d  = pix_cnt_q + 1'b1;
                        done_bit_d = 1'b1;
                        state_d    = (pix_cnt_q == PIX_LAST) ? LATCH : WAIT_PIX;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    cnt_d     = '0;
                    done_dz_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from next-cycle values so the registered pins line up with the state they describe.
        dout_d = (state_d == SEND) && (cnt_d < (shreg_d[23] ? HIGH_1 : HIGH_0));
        busy_d = (state_d != IDLE);
    end

endmodule

// File: doc/ws2812_tx.md
# ws2812_tx

WS2812 serial line driver: accepts 24-bit GRB pixel words over the LED upper interface, serializes them MSB-first onto a single NRZ data line at WS2812 bit timing, and closes each frame with a low latch (reset) period. Sits downstream of the spectrum-to-LED mapper, which supplies `start`/`valid`/`led_data` and paces itself on the `done_bit`/`done_dz` pulses this block returns. Drives the LED matrix data pin directly.

## Interface
- `NUM_LEDS`, 256, pixels per frame (BANDS×HEIGHT); ≥1
- `T0H`, 20, high cycles for a 0 bit (0.40 µs @ 50 MHz)
- `T1H`, 40, high cycles for a 1 bit (0.80 µs)
- `T_BIT`, 63, total cycles per bit (1.26 µs); constraint 0 < T0H < T1H < T_BIT
- `T_RESET`, 15000, latch low cycles after last pixel (300 µs)

- `clk_50m`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle frame-start request
- `valid`  in  1  `led_data` holds a pixel to send
- `led_data`  in  24  pixel, GRB, bit 23 (G7) sent first
- `done_bit`  out  1  one-cycle pulse: current pixel fully shifted out
- `done_dz`  out  1  one-cycle pulse: frame latch period complete
- `busy`  out  1  high in any state except IDLE
- `dout`  out  1  serial data to LED chain

## Operation
- States: IDLE, WAIT_PIX, SEND, LATCH. Counters: `cnt` (bit/latch timer, width clog2(max(T_BIT,T_RESET))), `bit_idx` (5 bits, 23..0), `pix_cnt` (clog2(NUM_LEDS+1)), 24-bit shift register.
- IDLE: `dout`=0. `start`=1 → WAIT_PIX, `pix_cnt`=0. If `start` and `valid` both 1: pixel captured, go directly to SEND.
- WAIT_PIX: `dout`=0. `valid`=1 → capture `led_data`, `bit_idx`=23, `cnt`=0, → SEND. No timeout; upstream keeps inter-pixel gap well below T_RESET (block does not guard).
- SEND: `dout`=1 while `cnt` < (current bit ? T1H : T0H), else 0. At `cnt`=T_BIT−1: if `bit_idx`>0 shift left, decrement, `cnt`=0; else pixel done → `pix_cnt`+1, `done_bit` pulse, next state LATCH (`cnt`=0) if `pix_cnt` was NUM_LEDS−1, else WAIT_PIX.
- LATCH: `dout`=0 for T_RESET cycles; at end → IDLE with `done_dz` pulse.
- `start` outside IDLE ignored; `valid` outside WAIT_PIX (and IDLE+start) ignored, data not captured.
- `done_bit` for final pixel still fires, followed by `done_dz` after latch.
- `rst` mid-operation: next cycle IDLE, all counters 0, `dout`=0, no `done_*` pulse; partial frame abandoned (chain resynchronizes on next frame's latch).

## Timing
- Reset values: `dout`=0, `done_bit`=0, `done_dz`=0, `busy`=0, state IDLE.
- All outputs registered.
- Pixel captured on edge ending cycle k → `dout` high cycles k+1 .. k+TH of first bit; bit n occupies cycles k+1+n·T_BIT .. k+(n+1)·T_BIT.
- `done_bit` high in cycle k+24·T_BIT+1 (state already WAIT_PIX/LATCH); `valid` in that same cycle is accepted (zero-gap back-to-back).
- Last pixel: LATCH spans cycles k+24·T_BIT+1 .. k+24·T_BIT+T_RESET; `done_dz` high cycle k+24·T_BIT+T_RESET+1, state IDLE; `start` accepted that cycle.
- `busy` falls with `done_dz` cycle.

## Test plan
- Reset: hold `rst` 3 cycles with `start`/`valid` toggling → all outputs 0, no state change; release → IDLE.
- Params T0H=2, T1H=4, T_BIT=6, T_RESET=10, NUM_LEDS=1; `start`+`valid` same cycle, `led_data`=0x800001 → bit 23 high 4 cycles, bits 22..1 high 2 cycles each, bit 0 high 4; `done_bit` exactly 145 cycles after capture, `done_dz` 10 cycles later.
- NUM_LEDS=3, pixels 0xFFFFFF, 0x000000, 0xA5A5A5 presented on the `done_bit` cycle → continuous waveform, 3 `done_bit`, 1 `done_dz`, `busy` high throughout.
- Inter-pixel gap of 7 cycles in WAIT_PIX → `dout` low during gap, second pixel timing shifted by 7, counts unchanged.
- `start` pulsed during SEND and `valid` held during LATCH → ignored; frame completes with exactly NUM_LEDS `done_bit`.
- `rst` asserted mid-bit of pixel 2 → `dout`=0 next cycle, no `done_*`; fresh `start` then transmits a full frame correctly.
